// File: rtl/match_matrix_scorer.sv
// Scores one N*N pairwise match matrix per handshake: total set bits, diagonal
// integrity and symmetry, scanned one row per cycle and held until consumed.
module match_matrix_scorer #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N-1:0]   match_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_count,
    output logic             diag_ok,
    output logic             sym_ok
);

    localparam int unsigned MAT_W = N * N;
    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = (MAT_W > 1) ? $clog2(MAT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [MAT_W-1:0]   mat_q, mat_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               diag_acc_q, diag_acc_d;
    logic               sym_acc_q, sym_acc_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               diag_ok_q, diag_ok_d;
    logic               sym_ok_q, sym_ok_d;
    logic               out_valid_q, out_valid_d;

    logic [CNT_W-1:0]   row_pop;
    logic               diag_bit;
    logic               sym_row;
    logic [CNT_W-1:0]   acc_sum;
    logic               diag_all;
    logic               sym_all;

    // Row r of the captured matrix: popcount, its diagonal bit, and mirror agreement.
    always_comb begin
        int unsigned r;
        logic [IDX_W-1:0] idx_rj;
        logic [IDX_W-1:0] idx_jr;
        row_pop  = '0;
        diag_bit = 1'b0;
        sym_row  = 1'b1;
        r        = 32'(row_q);
        for (int unsigned j = 0; j < N; j++) begin
            idx_rj  = IDX_W'(MAT_W - 1 - (N * r + j));
            idx_jr  = IDX_W'(MAT_W - 1 - (N * j + r));
            row_pop = row_pop + CNT_W'(mat_q[idx_rj]);
            sym_row = sym_row & (mat_q[idx_rj] == mat_q[idx_jr]);
            if (j == r) begin
                diag_bit = mat_q[idx_rj];
            end
        end
    end

    assign acc_sum  = acc_q + row_pop;
    assign diag_all = diag_acc_q & diag_bit;
    assign sym_all  = sym_acc_q & sym_row;

    // Next-state and output-register logic.
    always_comb begin
        state_d       = state_q;
        mat_d         = mat_q;
        acc_d         = acc_q;
        diag_acc_d    = diag_acc_q;
        sym_acc_d     = sym_acc_q;
        row_d         = row_q;
        match_count_d = match_count_q;
        diag_ok_d     = diag_ok_q;
        sym_ok_d      = sym_ok_q;
        out_valid_d   = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mat_d      = match_in;
                    acc_d      = '0;
                    diag_acc_d = 1'b1;
                    sym_acc_d  = 1'b1;
                    row_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                acc_d      = acc_sum;
                diag_acc_d = diag_all;
                sym_acc_d  = sym_all;
                if (row_q == ROW_W'(N - 1)) begin
                    match_count_d = acc_sum;
                    diag_ok_d     = diag_all;
                    sym_ok_d      = sym_all;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mat_q         <= '0;
            acc_q         <= '0;
            diag_acc_q    <= 1'b0;
            sym_acc_q     <= 1'b0;
            row_q         <= '0;
            match_count_q <= '0;
            diag_ok_q     <= 1'b0;
            sym_ok_q      <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mat_q         <= mat_d;
            acc_q         <= acc_d;
            diag_acc_q    <= diag_acc_d;
            sym_acc_q     <= sym_acc_d;
            row_q         <= row_d;
            match_count_q <= match_count_d;
            diag_ok_q     <= diag_ok_d;
            sym_ok_q      <= sym_ok_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Acceptance depends on state alone so upstream never sees a valid->ready path.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign match_count = match_count_q;
    assign diag_ok     = diag_ok_q;
    assign sym_ok      = sym_ok_q;

endmodule

// File: tb/tb_match_matrix_scorer.sv
// Directed bench for match_matrix_scorer: latency, scoring patterns,
// output back-pressure and asynchronous reset during a scan.
module tb_match_matrix_scorer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] match_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  match_count;
    logic        diag_ok;
    logic        sym_ok;

    int checks;
    int failures;

    match_matrix_scorer #(.N(5), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .match_in   (match_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .match_count(match_count),
        .diag_ok    (diag_ok),
        .sym_ok     (sym_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one matrix, scramble match_in after acceptance, return cycles to out_valid.
    task automatic send(input logic [24:0] mat, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_ready: in_ready=%0b required 1 within 30 cycles", in_ready);
        end
        in_valid = 1'b1;
        match_in = mat;
        @(posedge clk); #1;
        in_valid = 1'b0;
        match_in = ~mat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; match_in = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, match_count, diag_ok, sym_ok} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_vals: rdy=%0b vld=%0b cnt=%0d diag=%0b sym=%0b required 1 0 0 0 0",
                     in_ready, out_valid, match_count, diag_ok, sym_ok);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        int lat;
        out_ready = 1'b1;
        send(25'h1FFFFFF, lat);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL ones_latency: got %0d cycles required 5", lat);
        end
        checks++;
        if ({match_count, diag_ok, sym_ok, in_ready} !== {5'd25, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ones_result: cnt=%0d diag=%0b sym=%0b rdy=%0b required 25 1 1 0",
                     match_count, diag_ok, sym_ok, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, match_count} !== {1'b0, 1'b1, 5'd25}) begin
            failures++;
            $display("FAIL ones_release: vld=%0b rdy=%0b cnt=%0d required 0 1 25",
                     out_valid, in_ready, match_count);
        end
    endtask

    task automatic test_patterns();
        logic [24:0] mats  [3] = '{25'b10101_01010_10101_01010_10101, 25'h0000000, 25'h0800000};
        logic [4:0]  cnts  [3] = '{5'd13, 5'd0, 5'd1};
        logic        diags [3] = '{1'b1, 1'b0, 1'b0};
        logic        syms  [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(mats[k], lat);
            checks++;
            if ({out_valid, match_count, diag_ok, sym_ok} !== {1'b1, cnts[k], diags[k], syms[k]}) begin
                failures++;
                $display("FAIL pattern_%0d: vld=%0b cnt=%0d diag=%0b sym=%0b required 1 %0d %0b %0b",
                         k, out_valid, match_count, diag_ok, sym_ok, cnts[k], diags[k], syms[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(25'h0000000, lat);
        in_valid = 1'b1;
        match_in = 25'h1FFFFFF;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({out_valid, in_ready, match_count, diag_ok, sym_ok} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold_%0d: vld=%0b rdy=%0b cnt=%0d diag=%0b sym=%0b required 1 0 0 0 1",
                         c, out_valid, in_ready, match_count, diag_ok, sym_ok);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL bp_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: rdy=%0b required 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({lat[4:0], match_count, diag_ok, sym_ok} !== {5'd5, 5'd25, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bp_second: lat=%0d cnt=%0d diag=%0b sym=%0b required 5 25 1 1",
                     lat, match_count, diag_ok, sym_ok);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        match_in = 25'h1FFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, match_count, diag_ok, sym_ok} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_async: rdy=%0b vld=%0b cnt=%0d diag=%0b sym=%0b required 1 0 0 0 0",
                     in_ready, out_valid, match_count, diag_ok, sym_ok);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_nopulse: vld=%0b required 0", out_valid);
        end
        rst_n = 1'b1;
        send(25'h0800000, lat);
        checks++;
        if ({lat[4:0], match_count, diag_ok, sym_ok} !== {5'd5, 5'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_fresh: lat=%0d cnt=%0d diag=%0b sym=%0b required 5 1 0 0",
                     lat, match_count, diag_ok, sym_ok);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_all_ones();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
